// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU operation classes, funct codes
// understood by execute_module, and the packed control bundle carried in ID/EX.
package mips_defs;

   localparam int unsigned IDX_W   = 5;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned ALUOP_W = 3;
   localparam int unsigned INSTR_W = 32;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b000;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b011;

   localparam logic [FUNCT_W-1:0] FUNCT_ADD      = 6'b000000;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB      = 6'b000001;
   localparam logic [FUNCT_W-1:0] FUNCT_AND      = 6'b000010;
   localparam logic [FUNCT_W-1:0] FUNCT_OR       = 6'b000011;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT      = 6'b000100;
   localparam logic [FUNCT_W-1:0] FUNCT_SLL      = 6'b000101;
   localparam logic [FUNCT_W-1:0] FUNCT_SRL      = 6'b000110;
   localparam logic [FUNCT_W-1:0] FUNCT_ADD_MIPS = 6'b100000;

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               branch;
   } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32-entry architectural register file: two combinational read ports with
// same-cycle write-back bypass, one synchronous write port, $0 hard-wired to 0.
module register_file
   import mips_defs::*;
#(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_addr_1,
   input  logic [IDX_W-1:0]  rd_addr_2,
   output logic [DATA_W-1:0] rd_data_1_c,
   output logic [DATA_W-1:0] rd_data_2_c,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs [REG_COUNT];
   logic              wr_live_c;

   assign wr_live_c = wr_en && (wr_addr != '0);

   // Reset beats a simultaneous write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live_c) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_1_c = '0;
      if (rd_addr_1 != '0) begin
         rd_data_1_c = (wr_live_c && (wr_addr == rd_addr_1)) ? wr_data : regs[rd_addr_1];
      end
   end

   always_comb begin
      rd_data_2_c = '0;
      if (rd_addr_2 != '0) begin
         rd_data_2_c = (wr_live_c && (wr_addr == rd_addr_2)) ? wr_data : regs[rd_addr_2];
      end
   end

endmodule

// File: rtl/decode_module.sv
// MIPS instruction-decode stage: field split, register read, control decode,
// and the ID/EX pipeline register feeding execute_module.
module decode_module
   import mips_defs::*;
#(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   input  logic               stall,
   input  logic               flush,
   input  logic               wb_reg_write,
   input  logic [IDX_W-1:0]   wb_write_reg,
   input  logic [DATA_W-1:0]  wb_write_data,
   output logic [DATA_W-1:0]  alu_read_data_1,
   output logic [DATA_W-1:0]  alu_read_data_2,
   output logic [DATA_W-1:0]  immediate,
   output logic [FUNCT_W-1:0] funct,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src,
   output logic               reg_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               branch,
   output logic [IDX_W-1:0]   write_reg,
   output logic               out_valid,
   output logic               illegal_op
);

   logic [OP_W-1:0]   opcode_c;
   logic [IDX_W-1:0]  rs_c, rt_c, rd_c;
   logic [IDX_W-1:0]  rd_addr_1_c, rd_addr_2_c;
   logic [DATA_W-1:0] rd_data_1_c, rd_data_2_c;
   logic [DATA_W-1:0] imm_ext_c;
   ctrl_t             dec_ctrl_c;
   logic [IDX_W-1:0]  dec_wreg_c;
   logic              dec_illegal_c;

   ctrl_t             ctrl_q;
   logic [IDX_W-1:0]  rs_q, rt_q;

   assign opcode_c  = instr[31:26];
   assign rs_c      = instr[25:21];
   assign rt_c      = instr[20:16];
   assign rd_c      = instr[15:11];
   assign imm_ext_c = {{(DATA_W-16){instr[15]}}, instr[15:0]};

   // A held stage re-reads its own latched sources so write-backs land in it.
   assign rd_addr_1_c = (stall && !flush) ? rs_q : rs_c;
   assign rd_addr_2_c = (stall && !flush) ? rt_q : rt_c;

   register_file #(
      .REG_COUNT (REG_COUNT),
      .DATA_W    (DATA_W)
   ) u_register_file (
      .clk         (clk),
      .rst         (rst),
      .rd_addr_1   (rd_addr_1_c),
      .rd_addr_2   (rd_addr_2_c),
      .rd_data_1_c (rd_data_1_c),
      .rd_data_2_c (rd_data_2_c),
      .wr_en       (wb_reg_write),
      .wr_addr     (wb_write_reg),
      .wr_data     (wb_write_data)
   );

   always_comb begin
      dec_ctrl_c    = '0;
      dec_wreg_c    = '0;
      dec_illegal_c = 1'b0;
      case (opcode_c)
         OP_RTYPE: begin
            dec_ctrl_c.alu_op    = ALUOP_RTYPE;
            dec_ctrl_c.reg_write = 1'b1;
            dec_wreg_c           = rd_c;
         end
         OP_ADDI: begin
            dec_ctrl_c.alu_op    = ALUOP_ADD;
            dec_ctrl_c.alu_src   = 1'b1;
            dec_ctrl_c.reg_write = 1'b1;
            dec_wreg_c           = rt_c;
         end
         OP_LW: begin
            dec_ctrl_c.alu_op     = ALUOP_ADD;
            dec_ctrl_c.alu_src    = 1'b1;
            dec_ctrl_c.reg_write  = 1'b1;
            dec_ctrl_c.mem_read   = 1'b1;
            dec_ctrl_c.mem_to_reg = 1'b1;
            dec_wreg_c            = rt_c;
         end
         OP_SW: begin
            dec_ctrl_c.alu_op    = ALUOP_ADD;
            dec_ctrl_c.alu_src   = 1'b1;
            dec_ctrl_c.mem_write = 1'b1;
         end
         OP_BEQ: begin
            dec_ctrl_c.alu_op = ALUOP_SUB;
            dec_ctrl_c.branch = 1'b1;
         end
         default: dec_illegal_c = 1'b1;
      endcase
   end

   // ID/EX register: reset, then bubble, then stall-hold, then load.
   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && !instr_valid)) begin
         ctrl_q          <= '0;
         rs_q            <= '0;
         rt_q            <= '0;
         alu_read_data_1 <= '0;
         alu_read_data_2 <= '0;
         immediate       <= '0;
         funct           <= '0;
         write_reg       <= '0;
         out_valid       <= 1'b0;
         illegal_op      <= 1'b0;
      end else if (stall) begin
         alu_read_data_1 <= rd_data_1_c;
         alu_read_data_2 <= rd_data_2_c;
      end else begin
         ctrl_q          <= dec_ctrl_c;
         rs_q            <= rs_c;
         rt_q            <= rt_c;
         alu_read_data_1 <= rd_data_1_c;
         alu_read_data_2 <= rd_data_2_c;
         immediate       <= imm_ext_c;
         funct           <= instr[5:0];
         write_reg       <= dec_wreg_c;
         out_valid       <= 1'b1;
         illegal_op      <= dec_illegal_c;
      end
   end

   assign alu_op     = ctrl_q.alu_op;
   assign alu_src    = ctrl_q.alu_src;
   assign reg_write  = ctrl_q.reg_write;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign branch     = ctrl_q.branch;

endmodule

// File: tb/tb_decode_module.sv
// Directed bench for decode_module: decode table, bypass, stall refresh,
// flush/bubble priority, illegal opcodes and reset behaviour.
module tb_decode_module;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid, stall, flush;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic [31:0] alu_read_data_1, alu_read_data_2, immediate;
   logic [5:0]  funct;
   logic [2:0]  alu_op;
   logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch;
   logic [4:0]  write_reg;
   logic        out_valid, illegal_op;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decode_module dut (
      .clk             (clk),
      .rst             (rst),
      .instr           (instr),
      .instr_valid     (instr_valid),
      .stall           (stall),
      .flush           (flush),
      .wb_reg_write    (wb_reg_write),
      .wb_write_reg    (wb_write_reg),
      .wb_write_data   (wb_write_data),
      .alu_read_data_1 (alu_read_data_1),
      .alu_read_data_2 (alu_read_data_2),
      .immediate       (immediate),
      .funct           (funct),
      .alu_op          (alu_op),
      .alu_src         (alu_src),
      .reg_write       (reg_write),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_to_reg      (mem_to_reg),
      .branch          (branch),
      .write_reg       (write_reg),
      .out_valid       (out_valid),
      .illegal_op      (illegal_op)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
      wb_reg_write  = en;
      wb_write_reg  = r;
      wb_write_data = d;
   endtask

   task automatic chk_ctrl(input string tag, input logic [2:0] op, input logic src,
                           input logic rw, input logic mr, input logic mw,
                           input logic m2r, input logic br);
      chk({tag, ".ctrl"}, {25'd0, op, src, rw, mr, mw, m2r, br},
          {25'd0, alu_op, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch});
   endtask

   localparam logic [31:0] I_ADD   = 32'h0067_1020; // add $2,$3,$7
   localparam logic [31:0] I_ADD0  = 32'h0007_1020; // add $2,$0,$7
   localparam logic [31:0] I_ADD55 = 32'h00A5_1020; // add $2,$5,$5
   localparam logic [31:0] I_ADDI  = 32'h2062_FFFB; // addi $2,$3,-5
   localparam logic [31:0] I_LW    = 32'h8C62_0004; // lw $2,4($3)
   localparam logic [31:0] I_SW    = 32'hAC62_0004; // sw $2,4($3)
   localparam logic [31:0] I_BEQ   = 32'h1062_0004; // beq $3,$2,4
   localparam logic [31:0] I_ILL   = 32'hFC00_0000;

   initial begin
      rst = 1'b1; instr = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      wb(1'b0, 5'd0, 32'd0);
      #2;
      tick();
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.rd1", alu_read_data_1, 32'd0);
      chk_ctrl("rst", 3'd0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      wb(1'b1, 5'd3, 32'd3); tick();
      wb(1'b1, 5'd7, 32'd7); tick();
      wb(1'b0, 5'd0, 32'd0);

      instr = I_ADD; instr_valid = 1'b1; tick();
      chk("add.rd1", alu_read_data_1, 32'd3);
      chk("add.rd2", alu_read_data_2, 32'd7);
      chk("add.funct", 32'(funct), 32'h20);
      chk("add.wreg", 32'(write_reg), 32'd2);
      chk("add.valid", 32'(out_valid), 32'd1);
      chk("add.illegal", 32'(illegal_op), 32'd0);
      chk_ctrl("add", 3'b000, 0, 1, 0, 0, 0, 0);

      instr = I_ADDI; tick();
      chk("addi.imm", immediate, 32'hFFFF_FFFB);
      chk("addi.wreg", 32'(write_reg), 32'd2);
      chk("addi.rd1", alu_read_data_1, 32'd3);
      chk_ctrl("addi", 3'b011, 1, 1, 0, 0, 0, 0);

      instr = I_ADD; wb(1'b1, 5'd3, 32'h55); tick();
      chk("byp.rd1", alu_read_data_1, 32'h55);
      chk("byp.rd2", alu_read_data_2, 32'd7);

      instr = I_ADD0; wb(1'b1, 5'd0, 32'd9); tick();
      chk("r0byp.rd1", alu_read_data_1, 32'd0);
      wb(1'b0, 5'd0, 32'd0); tick();
      chk("r0.rd1", alu_read_data_1, 32'd0);

      instr = I_ADD; tick();
      chk("pre.rd1", alu_read_data_1, 32'h55);
      stall = 1'b1; instr = I_ADDI; tick();
      chk("st1.funct", 32'(funct), 32'h20);
      chk("st1.rd2", alu_read_data_2, 32'd7);
      wb(1'b1, 5'd7, 32'h99); tick();
      chk("st2.rd2", alu_read_data_2, 32'h99);
      chk("st2.wreg", 32'(write_reg), 32'd2);
      wb(1'b0, 5'd0, 32'd0); tick();
      chk("st3.rd2", alu_read_data_2, 32'h99);
      chk("st3.valid", 32'(out_valid), 32'd1);
      chk("st3.imm", immediate, 32'h0000_1020);
      chk_ctrl("st3", 3'b000, 0, 1, 0, 0, 0, 0);

      instr = I_LW; flush = 1'b1; tick();
      chk("fl.valid", 32'(out_valid), 32'd0);
      chk("fl.rd1", alu_read_data_1, 32'd0);
      chk_ctrl("fl", 3'd0, 0, 0, 0, 0, 0, 0);
      flush = 1'b0; stall = 1'b0; tick();
      chk_ctrl("lw", 3'b011, 1, 1, 1, 0, 1, 0);
      chk("lw.imm", immediate, 32'd4);
      chk("lw.wreg", 32'(write_reg), 32'd2);

      instr = I_SW; tick();
      chk_ctrl("sw", 3'b011, 1, 0, 0, 1, 0, 0);
      chk("sw.wreg", 32'(write_reg), 32'd0);
      instr = I_BEQ; tick();
      chk_ctrl("beq", 3'b001, 0, 0, 0, 0, 0, 1);
      chk("beq.wreg", 32'(write_reg), 32'd0);

      instr_valid = 1'b0; tick();
      chk("inv.valid", 32'(out_valid), 32'd0);
      chk_ctrl("inv", 3'd0, 0, 0, 0, 0, 0, 0);
      instr_valid = 1'b1;

      instr = I_ILL; tick();
      chk("ill.flag", 32'(illegal_op), 32'd1);
      chk("ill.valid", 32'(out_valid), 32'd1);
      chk_ctrl("ill", 3'd0, 0, 0, 0, 0, 0, 0);

      instr = I_ADD; tick();
      stall = 1'b1; rst = 1'b1; wb(1'b1, 5'd5, 32'h77); tick();
      chk("rstst.valid", 32'(out_valid), 32'd0);
      chk("rstst.rd1", alu_read_data_1, 32'd0);
      chk("rstst.funct", 32'(funct), 32'd0);
      chk_ctrl("rstst", 3'd0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0; stall = 1'b0; wb(1'b0, 5'd0, 32'd0);

      instr = I_ADD; tick();
      chk("clr.rd1", alu_read_data_1, 32'd0);
      chk("clr.rd2", alu_read_data_2, 32'd0);
      instr = I_ADD55; tick();
      chk("clr5.rd1", alu_read_data_1, 32'd0);

      wb(1'b1, 5'd5, 32'h42); tick();
      chk("rsrt.rd1", alu_read_data_1, 32'h42);
      chk("rsrt.rd2", alu_read_data_2, 32'h42);
      wb(1'b0, 5'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_module.md
Name: decode_module

Overview:
- Instruction-decode stage sitting directly upstream of execute_module.
- Splits a 32-bit MIPS instruction and reads rs/rt from an internal 32x32 register file with a write-back port.
- Produces sign-extended immediate, funct, alu_op, alu_src and memory/write-back control.
- Registers all of these in an ID/EX pipeline register that feeds execute_module's inputs one-for-one.

Parameters:
- REG_COUNT, 32, number of architectural registers (index width fixed at 5).
- DATA_W, 32, register and immediate width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction word from fetch
- instr_valid  in  1  instr carries a real instruction
- stall  in  1  hold ID/EX register
- flush  in  1  replace next ID/EX contents with bubble
- wb_reg_write  in  1  write-back enable
- wb_write_reg  in  5  write-back destination index
- wb_write_data  in  32  write-back data
- alu_read_data_1  out  32  rs value to execute
- alu_read_data_2  out  32  rt value to execute
- immediate  out  32  sign-extended instr[15:0]
- funct  out  6  instr[5:0]
- alu_op  out  3  ALU operation class
- alu_src  out  1  1 = immediate as ALU operand B
- reg_write, mem_read, mem_write, mem_to_reg, branch  out  1 each  downstream control
- write_reg  out  5  destination: rd for R-type, rt otherwise
- out_valid  out  1  ID/EX holds a real instruction
- illegal_op  out  1  valid instruction with an unknown opcode

Behaviour:
- Clock and reset: clk, single domain. rst is synchronous and active-high.
- Reset: every output is 0 and all register-file entries are 0, one edge after rst is sampled high.
- Fields: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], immediate = {16{instr[15]}, instr[15:0]}.
  - shamt remains inside immediate[10:6], which execute_module extracts.
- Decode table, as opcode -> alu_op/alu_src/reg_write/mem_read/mem_write/mem_to_reg/branch, write_reg:
  - 000000 R-type -> 000/0/1/0/0/0/0, rd
  - 001000 addi -> 011/1/1/0/0/0/0, rt
  - 100011 lw -> 011/1/1/1/0/1/0, rt
  - 101011 sw -> 011/1/0/0/1/0/0, write_reg 0
  - 000100 beq -> 001/0/0/0/0/0/1, write_reg 0
  - other -> all control 0, alu_op 000, illegal_op = 1.
- Latency: one cycle from instr to the ID/EX outputs.
- ID/EX update at each posedge, in priority order:
  1. rst: clear.
  2. flush: bubble. out_valid = 0, all controls = 0, illegal_op = 0, data fields = 0.
  3. stall: hold control, immediate, funct and write_reg. Re-read alu_read_data_1/2 from the latched rs/rt indices, so write-backs during a stall are seen.
  4. Otherwise: load the decode of instr. out_valid = instr_valid.
- instr_valid = 0 outside flush: loads a bubble identical to flush.
- Register file:
  - Write at posedge when wb_reg_write = 1 and wb_write_reg != 0. Writes to $0 are ignored, and $0 always reads 0.
  - Writes occur regardless of stall or flush. They are blocked only by rst, and rst has priority over a simultaneous write.
- Read bypass: if wb_reg_write and wb_write_reg == the source index (nonzero) in the same cycle, the captured read value is wb_write_data, not the old entry.
  - Applies to both normal load and stall refresh.
- rs == rt: both outputs carry the same value, including under bypass.
- rst mid-stall: clear wins. out_valid = 0 next cycle.

Decomposition:
- Package mips_defs: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ), alu_op codes (ALUOP_RTYPE = 000, ALUOP_SUB = 001, ALUOP_ADD = 011), funct codes shared with execute_module (000000 add, 000001 sub, 000010 and, 000011 or, 000100 slt, 000101 sll, 000110 srl, 100000 add), and a control-bundle struct.
- One sub-module: register_file. It holds the 32x32 array with two combinational read ports, one synchronous write port, the $0 rule and the bypass.
- Decode logic and the ID/EX register stay in decode_module.

Test Plan:
- Reset, then R-type add: rst 1 cycle, then write $3 = 3 and $7 = 7 via WB, then instr = 0x00671020. Next cycle: alu_read_data_1 = 3, alu_read_data_2 = 7, funct = 100000, alu_op = 000, alu_src = 0, write_reg = 2, reg_write = 1, out_valid = 1.
- addi with negative immediate: instr = 0x2062FFFB (addi $2, $3, -5). Required: immediate = 0xFFFFFFFB, alu_op = 011, alu_src = 1, write_reg = 2.
- Bypass: WB writes $3 = 0x55 in the same cycle that the add is decoded. Required: alu_read_data_1 = 0x55. Separately, a WB write to $0 = 9 leaves $0 reading 0.
- Stall refresh: hold stall = 1 for 3 cycles with the add held, while WB writes $7 = 0x99. Required: control/funct unchanged, alu_read_data_2 = 0x99 after the write edge, out_valid stays 1.
- flush + stall together on lw (0x8C620004). Required: bubble next cycle (out_valid = 0, mem_read = 0, reg_write = 0).
- Illegal and mid-stall reset: opcode 111111 with instr_valid = 1 gives illegal_op = 1 and all control 0. Then rst during a stall gives all outputs 0 and all registers reading 0.
